alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Controller sitting in front of the 4-bit ALU datapath (add/sub/mul/div, opcodes 000-011).
- Accepts operand/opcode commands over a valid/ready handshake, drives the ALU with stable registered operands for a programmable settle time, captures result and flags, and presents them on a valid/ready result port.
- Screens illegal opcodes and divide-by-zero before they reach the ALU; counts completed operations.

Parameters:
- ALU_LAT, 1, cycles the ALU inputs are held before capture; legal 1..15.
- CNT_W, 8, width of completed-operation counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- ena  in  1  global enable; 0 freezes the block
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid&ready
- cmd_a  in  4  operand A
- cmd_b  in  4  operand B
- cmd_op  in  3  opcode
- cmd_chain  in  1  use previous result as A (optional feature only)
- alu_a  out  4  ALU operand A
- alu_b  out  4  ALU operand B
- alu_op  out  3  ALU opcode
- alu_result  in  8  ALU result
- alu_ovf  in  1  ALU overflow flag
- res_valid  out  1  result available
- res_ready  in  1  result consumed when valid&ready
- res_data  out  8  captured result
- res_zero  out  1  res_data==0
- res_ovf  out  1  captured overflow
- res_err  out  1  illegal opcode or divide-by-zero
- op_count  out  CNT_W  completed operations, wraps

Behaviour:
- Clock clk; reset synchronous, active-low on rst_n. Reset (also mid-operation): state IDLE, pending command discarded, all outputs 0, op_count 0, wait counter 0.
- States: IDLE, EXEC, DONE.
- cmd_ready = ena & (IDLE | (DONE & res_ready)); back-to-back issue allowed in same cycle as result consume.
- Accept: latch cmd_a/b/op into operand regs; alu_a/b/op driven only from these regs, stable from the cycle after acceptance until next acceptance.
- Legal op (000-010, or 011 with b!=0): IDLE->EXEC, counter loaded with ALU_LAT-1; decrement each enabled cycle; at counter==0 capture alu_result, alu_ovf into res regs, res_zero=(alu_result==0), res_err=0, ->DONE. res_valid rises exactly ALU_LAT cycles after acceptance edge.
- Illegal op (1xx) or 011 with b==0: skip EXEC, ->DONE next cycle; res_data=0, res_zero=1, res_ovf=0, res_err=1; ALU regs still updated.
- DONE: res_valid=1 and res_* stable until res_ready; on handshake op_count+=1 (errors included), ->IDLE, or ->EXEC/DONE if a new command accepted same cycle.
- op_count wraps 2^CNT_W-1 -> 0.
- ena=0: all state, counters and registers frozen; cmd_ready=0, res_valid masked to 0; no handshake completes; resumes exactly where frozen.
- cmd_valid while busy: ignored (ready low); upstream must hold.

Optional Feature:
- Macro ALU_SEQ_CHAIN_EN.
- Defined: on accept with cmd_chain=1, operand A = res_data[3:0] of the last completed result (0 after reset), cmd_a ignored; error results still chain (A=0).
- Undefined: cmd_chain ignored, A always from cmd_a; port stays for interface stability.

Test Plan:
- Reset then cmd a=3,b=4,op=000, ALU_LAT=1 -> cmd_ready high in IDLE; res_valid one cycle after accept, res_data=0x07, zero=0, err=0, op_count=1 after consume.
- a=5,b=0,op=011 -> no EXEC; res_valid next cycle, res_data=0, res_zero=1, res_err=1.
- op=101 -> res_err=1, res_data=0; op_count still increments on consume.
- ALU_LAT=3, a=7,b=6,op=010 with res_ready held 0 for 5 cycles -> res_valid at accept+3, res_data=0x2A stable throughout hold; second command refused until consume.
- ena dropped 2 cycles mid-EXEC, then rst_n=0 one cycle during EXEC -> ena: latency extended by 2 cycles; reset: IDLE, outputs 0, op_count 0, no res_valid.
- ALU_SEQ_CHAIN_EN: a=2,b=3 add (res 5), then chain b=4 op=010 -> alu_a=5, res_data=0x14.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// Command/result handshake bundle between an upstream requester and alu_op_sequencer.
interface alu_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [2:0] cmd_op;
  logic       cmd_chain;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_zero;
  logic       res_ovf;
  logic       res_err;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_chain, res_ready,
    input  cmd_ready, res_valid, res_data, res_zero, res_ovf, res_err
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_chain, res_ready,
    output cmd_ready, res_valid, res_data, res_zero, res_ovf, res_err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequencer in front of a 4-bit ALU: screens commands, holds operands ALU_LAT cycles, returns results.
// Optional macro ALU_SEQ_CHAIN_EN: cmd_chain=1 takes operand A from the low nibble of the last result.
module alu_op_sequencer #(
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  alu_seq_if.slave         bus,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [2:0]       alu_op,
  input  logic [7:0]       alu_result,
  input  logic             alu_ovf,
  output logic [CNT_W-1:0] op_count
);

  localparam int unsigned WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic [3:0]        a_nxt, b_nxt;
  logic [2:0]        op_nxt;
  logic [7:0]        res_data_q, data_nxt;
  logic              res_zero_q, zero_nxt;
  logic              res_ovf_q, ovf_nxt;
  logic              res_err_q, err_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              ready_c;
  logic              accept_c;
  logic              legal_c;
  logic [3:0]        a_src_c;

  // Ready in IDLE, or in DONE when the current result is consumed in the same cycle.
  assign ready_c  = ena & ((state == IDLE) | ((state == DONE) & bus.res_ready));
  assign accept_c = bus.cmd_valid & ready_c;
  assign legal_c  = ~bus.cmd_op[2] & ~((bus.cmd_op[1:0] == 2'b11) & (bus.cmd_b == 4'd0));

`ifdef ALU_SEQ_CHAIN_EN
  assign a_src_c = bus.cmd_chain ? res_data_q[3:0] : bus.cmd_a;
`else
  logic unused_chain;
  assign unused_chain = bus.cmd_chain;
  assign a_src_c      = bus.cmd_a;
`endif

  assign bus.cmd_ready = ready_c;
  assign bus.res_valid = ena & (state == DONE);
  assign bus.res_data  = res_data_q;
  assign bus.res_zero  = res_zero_q;
  assign bus.res_ovf   = res_ovf_q;
  assign bus.res_err   = res_err_q;

  // Next-state and next-register values; ena=0 leaves everything at its current value.
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    a_nxt     = alu_a;
    b_nxt     = alu_b;
    op_nxt    = alu_op;
    data_nxt  = res_data_q;
    zero_nxt  = res_zero_q;
    ovf_nxt   = res_ovf_q;
    err_nxt   = res_err_q;
    cnt_nxt   = op_count;

    if (ena) begin
      case (state)
        EXEC: begin
          if (wait_cnt == '0) begin
            data_nxt  = alu_result;
            zero_nxt  = (alu_result == 8'd0);
            ovf_nxt   = alu_ovf;
            err_nxt   = 1'b0;
            state_nxt = DONE;
          end else begin
            wait_nxt = wait_cnt - WAIT_W'(1);
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            cnt_nxt   = op_count + CNT_W'(1);
            state_nxt = IDLE;
          end
        end
        default: ;
      endcase

      // A new command overrides the DONE->IDLE move when issued back-to-back.
      if (accept_c) begin
        a_nxt  = a_src_c;
        b_nxt  = bus.cmd_b;
        op_nxt = bus.cmd_op;
        if (legal_c) begin
          state_nxt = EXEC;
          wait_nxt  = WAIT_W'(ALU_LAT - 1);
        end else begin
          state_nxt = DONE;
          data_nxt  = 8'd0;
          zero_nxt  = 1'b1;
          ovf_nxt   = 1'b0;
          err_nxt   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      res_data_q <= '0;
      res_zero_q <= 1'b0;
      res_ovf_q  <= 1'b0;
      res_err_q  <= 1'b0;
      op_count   <= '0;
    end else begin
      state      <= state_nxt;
      wait_cnt   <= wait_nxt;
      alu_a      <= a_nxt;
      alu_b      <= b_nxt;
      alu_op     <= op_nxt;
      res_data_q <= data_nxt;
      res_zero_q <= zero_nxt;
      res_ovf_q  <= ovf_nxt;
      res_err_q  <= err_nxt;
      op_count   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: lane 0 (ALU_LAT=1, CNT_W=8) and lane 1 (ALU_LAT=3, CNT_W=4),
// directed scenarios then random traffic against a transaction-level model.
module tb_alu_op_sequencer;

  localparam int unsigned LAT0 = 1;
  localparam int unsigned LAT1 = 3;
  localparam int unsigned CW0  = 8;
  localparam int unsigned CW1  = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena       [2];
  logic       cmd_valid [2];
  logic       cmd_chain [2];
  logic       res_ready [2];
  logic [3:0] cmd_a     [2];
  logic [3:0] cmd_b     [2];
  logic [2:0] cmd_op    [2];

  logic       cmd_ready_o [2];
  logic       res_valid_o [2];
  logic       res_zero_o  [2];
  logic       res_ovf_o   [2];
  logic       res_err_o   [2];
  logic [7:0] res_data_o  [2];
  logic [3:0] alu_a_o     [2];
  logic [3:0] alu_b_o     [2];
  logic [2:0] alu_op_o    [2];
  logic [7:0] op_count_o  [2];

  int ncmp = 0;
  int nerr = 0;

  // Transaction-level model state per lane
  int         mdl_cnt  [2];
  logic [3:0] mdl_last [2];
  bit         pend     [2];
  logic [7:0] exp_data [2];
  logic       exp_zero [2];
  logic       exp_ovf  [2];
  logic       exp_err  [2];
  int         exp_lat  [2];
  logic [3:0] exp_a    [2];

  always #5 clk = ~clk;

  // External 4-bit ALU: {ovf, result}
  function automatic logic [8:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    logic [7:0] r;
    logic       o;
    r = 8'd0;
    o = 1'b0;
    case (op)
      3'd0: begin r = 8'(a) + 8'(b); o = (r > 8'd15); end
      3'd1: begin r = 8'(a) - 8'(b); o = (a < b); end
      3'd2: begin r = 8'(a) * 8'(b); o = (r > 8'd15); end
      3'd3: if (b != 4'd0) r = 8'(a / b);
      default: ;
    endcase
    return {o, r};
  endfunction

  function automatic int lat_of(input int l);
    return (l == 0) ? int'(LAT0) : int'(LAT1);
  endfunction

  function automatic int wrap_of(input int l);
    return (l == 0) ? (1 << CW0) : (1 << CW1);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int unsigned LAT = (g == 0) ? LAT0 : LAT1;
    localparam int unsigned CW  = (g == 0) ? CW0 : CW1;

    alu_seq_if bus ();
    logic [3:0]    a_w, b_w;
    logic [2:0]    op_w;
    logic [8:0]    alu_out;
    logic [CW-1:0] cnt_w;

    assign bus.cmd_valid = cmd_valid[g];
    assign bus.cmd_a     = cmd_a[g];
    assign bus.cmd_b     = cmd_b[g];
    assign bus.cmd_op    = cmd_op[g];
    assign bus.cmd_chain = cmd_chain[g];
    assign bus.res_ready = res_ready[g];
    assign alu_out       = alu_fn(a_w, b_w, op_w);

    alu_op_sequencer #(.ALU_LAT(LAT), .CNT_W(CW)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena[g]),
      .bus        (bus),
      .alu_a      (a_w),
      .alu_b      (b_w),
      .alu_op     (op_w),
      .alu_result (alu_out[7:0]),
      .alu_ovf    (alu_out[8]),
      .op_count   (cnt_w)
    );

    assign cmd_ready_o[g] = bus.cmd_ready;
    assign res_valid_o[g] = bus.res_valid;
    assign res_data_o[g]  = bus.res_data;
    assign res_zero_o[g]  = bus.res_zero;
    assign res_ovf_o[g]   = bus.res_ovf;
    assign res_err_o[g]   = bus.res_err;
    assign alu_a_o[g]     = a_w;
    assign alu_b_o[g]     = b_w;
    assign alu_op_o[g]    = op_w;
    assign op_count_o[g]  = 8'(cnt_w);
  end

  task automatic check(input string tag, input int l, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s lane%0d: observed %0h expected %0h", tag, l, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < 2; l++) begin
      mdl_cnt[l]  = 0;
      mdl_last[l] = 4'd0;
      pend[l]     = 1'b0;
    end
  endtask

  task automatic check_idle_reset(input int l);
    check("rst_valid", l, res_valid_o[l], 0);
    check("rst_data",  l, res_data_o[l], 0);
    check("rst_zero",  l, res_zero_o[l], 0);
    check("rst_ovf",   l, res_ovf_o[l], 0);
    check("rst_err",   l, res_err_o[l], 0);
    check("rst_alu",   l, {alu_a_o[l], alu_b_o[l], alu_op_o[l]}, 0);
    check("rst_count", l, op_count_o[l], 0);
  endtask

  // Present a command at a negedge; rr=1 consumes the pending result on the same edge.
  task automatic start(input int l, input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] op, input logic chain, input logic rr);
    logic [3:0] a_eff;
    logic [8:0] r;
    logic       legal;
    cmd_a[l] = a; cmd_b[l] = b; cmd_op[l] = op; cmd_chain[l] = chain;
    cmd_valid[l] = 1'b1;
    res_ready[l] = rr;
    #1;
    check("cmd_ready", l, cmd_ready_o[l], 1);
`ifdef ALU_SEQ_CHAIN_EN
    a_eff = chain ? mdl_last[l] : a;
`else
    a_eff = a;
`endif
    legal = (op < 3'd3) || (op == 3'd3 && b != 4'd0);
    r     = alu_fn(a_eff, b, op);
    @(posedge clk);
    if (pend[l] && rr) begin
      mdl_cnt[l] = (mdl_cnt[l] + 1) % wrap_of(l);
      pend[l]    = 1'b0;
    end
    @(negedge clk);
    cmd_valid[l] = 1'b0;
    res_ready[l] = 1'b0;
    check("alu_a",  l, alu_a_o[l], a_eff);
    check("alu_b",  l, alu_b_o[l], b);
    check("alu_op", l, alu_op_o[l], op);
    exp_a[l]    = a_eff;
    exp_data[l] = legal ? r[7:0] : 8'd0;
    exp_ovf[l]  = legal ? r[8] : 1'b0;
    exp_err[l]  = ~legal;
    exp_zero[l] = (exp_data[l] == 8'd0);
    exp_lat[l]  = legal ? lat_of(l) : 0;
  endtask

  // Wait for the result; latency counted in edges after the acceptance edge.
  task automatic finish(input int l, input bit freeze);
    int lat = 0;
    while (!res_valid_o[l] && lat < 40) begin
      if (freeze && lat == 1) begin
        ena[l] = 1'b0;
        repeat (2) begin
          @(posedge clk); @(negedge clk);
          check("frz_valid", l, res_valid_o[l], 0);
          check("frz_ready", l, cmd_ready_o[l], 0);
        end
        ena[l] = 1'b1;
        lat += 2;
      end else begin
        check("busy_ready", l, cmd_ready_o[l], 0);
        @(posedge clk); @(negedge clk);
        lat++;
      end
    end
    check("latency",  l, lat, exp_lat[l] + (freeze ? 2 : 0));
    check("res_data", l, res_data_o[l], exp_data[l]);
    check("res_zero", l, res_zero_o[l], exp_zero[l]);
    check("res_ovf",  l, res_ovf_o[l], exp_ovf[l]);
    check("res_err",  l, res_err_o[l], exp_err[l]);
    check("op_count", l, op_count_o[l], mdl_cnt[l]);
    mdl_last[l] = exp_data[l][3:0];
    pend[l]     = 1'b1;
  endtask

  // Hold res_ready low for hold cycles while a competing command is offered, then consume.
  task automatic consume(input int l, input int hold);
    for (int i = 0; i < hold; i++) begin
      cmd_a[l] = 4'($urandom); cmd_b[l] = 4'($urandom); cmd_op[l] = 3'd0;
      cmd_valid[l] = 1'b1;
      #1;
      check("hold_ready", l, cmd_ready_o[l], 0);
      @(posedge clk); @(negedge clk);
      check("hold_valid", l, res_valid_o[l], 1);
      check("hold_data",  l, res_data_o[l], exp_data[l]);
      check("hold_alu_a", l, alu_a_o[l], exp_a[l]);
    end
    cmd_valid[l] = 1'b0;
    res_ready[l] = 1'b1;
    @(posedge clk); @(negedge clk);
    res_ready[l] = 1'b0;
    mdl_cnt[l] = (mdl_cnt[l] + 1) % wrap_of(l);
    pend[l]    = 1'b0;
    check("post_valid", l, res_valid_o[l], 0);
    check("post_count", l, op_count_o[l], mdl_cnt[l]);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int l = 0; l < 2; l++) begin
      ena[l] = 1'b1; cmd_valid[l] = 1'b0; cmd_chain[l] = 1'b0; res_ready[l] = 1'b0;
      cmd_a[l] = 4'd0; cmd_b[l] = 4'd0; cmd_op[l] = 3'd0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int l = 0; l < 2; l++) check_idle_reset(l);
    rst_n = 1'b1;

    // Lane 0: add, divide-by-zero, illegal opcode
    start(0, 4'd3, 4'd4, 3'd0, 1'b0, 1'b0); finish(0, 1'b0);
    check("add_data", 0, res_data_o[0], 8'h07);
    consume(0, 0);
    check("add_count", 0, op_count_o[0], 1);
    start(0, 4'd5, 4'd0, 3'd3, 1'b0, 1'b0); finish(0, 1'b0);
    consume(0, 1);
    start(0, 4'd6, 4'd2, 3'd5, 1'b0, 1'b0); finish(0, 1'b0);
    consume(0, 0);
    check("err_count", 0, op_count_o[0], 3);

    // Lane 1: multiply with long result hold, then ena freeze mid-EXEC
    start(1, 4'd7, 4'd6, 3'd2, 1'b0, 1'b0); finish(1, 1'b0);
    check("mul_data", 1, res_data_o[1], 8'h2A);
    consume(1, 5);
    start(1, 4'd9, 4'd2, 3'd0, 1'b0, 1'b0); finish(1, 1'b1);
    consume(1, 0);

    // Reset in the middle of EXEC
    start(1, 4'd2, 4'd2, 3'd2, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int l = 0; l < 2; l++) check_idle_reset(l);
    repeat (4) begin
      @(posedge clk); @(negedge clk);
      check("rst_novalid", 1, res_valid_o[1], 0);
      check("rst_ready",   1, cmd_ready_o[1], 1);
    end

`ifdef ALU_SEQ_CHAIN_EN
    start(0, 4'd2, 4'd3, 3'd0, 1'b0, 1'b0); finish(0, 1'b0);
    consume(0, 0);
    start(0, 4'd0, 4'd4, 3'd2, 1'b1, 1'b0);
    check("chain_a", 0, alu_a_o[0], 5);
    finish(0, 1'b0);
    check("chain_data", 0, res_data_o[0], 8'h14);
    consume(0, 0);
`endif

    // Random traffic, including back-to-back issue on result consume
    for (int it = 0; it < 300; it++) begin
      int         l;
      logic [2:0] op;
      bit         b2b;
      l   = int'($urandom_range(0, 1));
      op  = ($urandom_range(0, 3) != 0) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      b2b = pend[l] && ($urandom_range(0, 1) == 1);
      if (pend[l] && !b2b) consume(l, int'($urandom_range(0, 2)));
      start(l, 4'($urandom), 4'($urandom), op, 1'($urandom), b2b);
      finish(l, 1'b0);
    end
    for (int l = 0; l < 2; l++) if (pend[l]) consume(l, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
